// File: rtl/pwm_capture_pkg.sv
// Shared FSM state encoding and input-conditioning constants for pwm_capture.
// Define PWM_CAPTURE_FILTER_EN to add the 3-cycle glitch filter, which lengthens the settle time.
package pwm_capture_pkg;

    typedef enum logic [2:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        LOW,
        STUCK
    } state_t;

    localparam int FILTER_LEN   = 3;
    localparam int SYNC_LATENCY = 3;

    // Cycles from reset release until the conditioned level reflects the real pin.
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int SETTLE_CYCLES = SYNC_LATENCY + FILTER_LEN - 1;
`else
    localparam int SETTLE_CYCLES = SYNC_LATENCY;
`endif

endpackage

// File: rtl/pwm_capture_input_cond.sv
// pwm_input_cond: 2-FF synchroniser, optional glitch filter (PWM_CAPTURE_FILTER_EN),
// and rise/fall detection against the previous conditioned sample.
module pwm_input_cond
    import pwm_capture_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_meta;
    logic sync_q;
    logic level_q;
    logic level_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= pwm_in;
            sync_q    <= sync_meta;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] filt_cnt;

    // The level only follows the synchroniser once it has disagreed for FILTER_LEN cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_q != level_q) begin
            if (filt_cnt == 2'(FILTER_LEN - 1)) begin
                level_q  <= sync_q;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 2'd1;
            end
        end else begin
            filt_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= sync_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev;
    assign fall  = ~level_q & level_prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in clk cycles,
// with stuck-line detection. Glitch filter enabled by PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] SETTLE  = CNT_W'(SETTLE_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi;
    logic             level;
    logic             rise;
    logic             fall;
    logic             at_max;
    logic             timeout;

    pwm_input_cond u_cond (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    assign at_max  = (cnt == CNT_MAX);
    assign cnt_inc = at_max ? cnt : cnt + 1'b1;
    assign timeout = at_max & ~rise & ~fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT_LOW ignores the reset-zero level until the conditioning pipeline has flushed,
    // so a pin that is already high at reset cannot start a partial measurement.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOW: begin
                if (!level && (fall || cnt >= SETTLE)) state_nxt = WAIT_RISE;
                else if (timeout)                      state_nxt = STUCK;
            end
            WAIT_RISE: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = STUCK;
            end
            HIGH: begin
                if (fall)         state_nxt = LOW;
                else if (timeout) state_nxt = STUCK;
            end
            LOW: begin
                if (rise)         state_nxt = HIGH;
                else if (timeout) state_nxt = STUCK;
            end
            STUCK: begin
                if (rise)      state_nxt = HIGH;
                else if (fall) state_nxt = WAIT_RISE;
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    always_comb begin
        stuck       = (state == STUCK);
        stuck_level = (state == STUCK) & level;
    end

    // cnt runs from the measuring rise through HIGH and LOW; outside a measurement it counts since the last edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            hi        <= '0;
            high_time <= '0;
            period    <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                HIGH: begin
                    cnt <= cnt_inc;
                    if (fall) hi <= cnt;
                end
                LOW: begin
                    if (rise) begin
                        high_time <= hi;
                        period    <= cnt;
                        valid     <= 1'b1;
                        cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                STUCK: begin
                    if (rise || fall) cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    if (rise || fall) cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                    else              cnt <= cnt_inc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives per-cycle PWM patterns into pwm_capture (CNT_W=8) and compares every cycle
// against an edge-timeline model of the measurement rules.
module tb_pwm_capture;

    localparam int CNT_W = 8;
    localparam int MAXN  = 1200;
    localparam int LIMIT = 255;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int COND_DELAY = 2;
`else
    localparam int COND_DELAY = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck;
    logic             stuck_level;

    int vectors = 0;
    int miscompares = 0;

    bit stim[MAXN];
    bit cond[MAXN];
    int n;
    bit exp_valid[MAXN];
    bit exp_stuck[MAXN];
    bit exp_sl[MAXN];
    int exp_hi[MAXN];
    int exp_per[MAXN];

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .high_time   (high_time),
        .period      (period),
        .valid       (valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    task automatic add_run(input bit v, input int len);
        for (int i = 0; i < len; i++) begin
            if (n < MAXN) begin
                stim[n] = v;
                n++;
            end
        end
    endtask

    function automatic bit cget(input int t);
        return (t < 0) ? 1'b0 : cond[t];
    endfunction

    // Conditioned level per sample, then walk its edges: the FSM acts on sample t at edge t+3.
    function automatic void build_model();
        int ref_t = -3;
        int r0 = 0;
        int f = 0;
        int hi_h = 0;
        int per_h = 0;
        bit meas = 0;
        bit fs = 0;
        bit stk = 0;
        for (int t = 0; t < n; t++) begin
`ifdef PWM_CAPTURE_FILTER_EN
            if (t >= 2 && stim[t] == stim[t-1] && stim[t-1] == stim[t-2])
                cond[t] = stim[t];
            else
                cond[t] = cget(t - 1);
`else
            cond[t] = stim[t];
`endif
        end
        for (int t = -3; t <= n - 4; t++) begin
            bit rise = cget(t) & ~cget(t - 1);
            bit fall = ~cget(t) & cget(t - 1);
            bit v = 0;
            int k = t + 3;
            if (stk) begin
                if (rise) begin
                    stk = 0; meas = 1; fs = 0; r0 = t;
                end else if (fall) begin
                    stk = 0; ref_t = t;
                end
            end else if (meas) begin
                if (rise && fs) begin
                    v = 1;
                    hi_h = (f - r0 > LIMIT) ? LIMIT : f - r0;
                    per_h = (t - r0 > LIMIT) ? LIMIT : t - r0;
                    r0 = t; fs = 0;
                end else if (fall) begin
                    fs = 1; f = t;
                end else if (!rise && t - r0 >= LIMIT) begin
                    stk = 1; meas = 0;
                end
            end else begin
                if (rise && t > COND_DELAY) begin
                    meas = 1; fs = 0; r0 = t;
                end else if (rise || fall) begin
                    ref_t = t;
                end else if (t - ref_t >= LIMIT) begin
                    stk = 1;
                end
            end
            exp_valid[k] = v;
            exp_hi[k]    = hi_h;
            exp_per[k]   = per_h;
            exp_stuck[k] = stk;
            exp_sl[k]    = stk & cget(k - 2);
        end
    endfunction

    function automatic logic [2*CNT_W+2:0] observed();
        return {valid, stuck, stuck_level, high_time, period};
    endfunction

    function automatic logic [2*CNT_W+2:0] expected(input int k);
        return {exp_valid[k], exp_stuck[k], exp_sl[k], CNT_W'(exp_hi[k]), CNT_W'(exp_per[k])};
    endfunction

    task automatic do_reset(input bit lvl);
        rst = 1'b1;
        pwm_in = lvl;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit v);
        pwm_in = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n = 0;
        add_run(0, 12);
        build_model();
        do_reset(1'b0);
        vectors++;
        if (observed() !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_values got %h expected 0", observed());
        end
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL idle k=%0d got %h expected %h", k, observed(), expected(k));
            end
        end
    endtask

    task automatic test_steady();
        int nvalid = 0;
        n = 0;
        add_run(0, 4);
        for (int i = 0; i < 10; i++) begin
            add_run(1, 3);
            add_run(0, 5);
        end
        add_run(0, 6);
        build_model();
        do_reset(1'b0);
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL steady k=%0d got %h expected %h", k, observed(), expected(k));
            end
            if (valid) nvalid++;
        end
        vectors++;
        if (nvalid != 9 || high_time !== 8'd3 || period !== 8'd8) begin
            miscompares++;
            $display("[TB] FAIL steady_summary got valids=%0d hi=%0d per=%0d expected 9/3/8",
                     nvalid, high_time, period);
        end
    endtask

    task automatic test_high_at_reset();
        int nvalid = 0;
        int first_hi = -1;
        int first_per = -1;
        n = 0;
        add_run(1, 4);
        for (int i = 0; i < 5; i++) begin
            add_run(0, 4);
            add_run(1, 4);
        end
        add_run(0, 6);
        build_model();
        do_reset(1'b1);
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL high_at_reset k=%0d got %h expected %h", k, observed(), expected(k));
            end
            if (valid) begin
                if (nvalid == 0) begin
                    first_hi = int'(high_time);
                    first_per = int'(period);
                end
                nvalid++;
            end
        end
        vectors++;
        if (nvalid != 4 || first_hi != 4 || first_per != 8) begin
            miscompares++;
            $display("[TB] FAIL high_at_reset_first got valids=%0d hi=%0d per=%0d expected 4/4/8",
                     nvalid, first_hi, first_per);
        end
    endtask

    task automatic test_glitch();
        int nvalid = 0;
        n = 0;
        add_run(0, 6);
        for (int i = 0; i < 4; i++) begin
            add_run(1, 1);
            add_run(0, 10);
        end
        add_run(0, 6);
        build_model();
        do_reset(1'b0);
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL glitch k=%0d got %h expected %h", k, observed(), expected(k));
            end
            if (valid) nvalid++;
        end
        vectors++;
`ifdef PWM_CAPTURE_FILTER_EN
        if (nvalid != 0 || high_time !== 8'd0 || period !== 8'd0) begin
`else
        if (nvalid != 3 || high_time !== 8'd1 || period !== 8'd11) begin
`endif
            miscompares++;
            $display("[TB] FAIL glitch_summary got valids=%0d hi=%0d per=%0d", nvalid, high_time, period);
        end
    endtask

    task automatic test_stuck();
        int last_rise;
        int first_stuck = -1;
        int sl_high = 0;
        int sl_low = 0;
        n = 0;
        add_run(0, 5); add_run(1, 3); add_run(0, 5); add_run(1, 3); add_run(0, 5);
        last_rise = n;
        add_run(1, 300);
        add_run(0, 6);
        for (int i = 0; i < 2; i++) begin
            add_run(1, 4);
            add_run(0, 6);
        end
        add_run(0, 300);
        for (int i = 0; i < 2; i++) begin
            add_run(1, 4);
            add_run(0, 6);
        end
        add_run(0, 6);
        build_model();
        do_reset(1'b0);
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL stuck k=%0d got %h expected %h", k, observed(), expected(k));
            end
            if (stuck && first_stuck < 0) first_stuck = k;
            if (stuck && stuck_level) sl_high++;
            if (stuck && !stuck_level) sl_low++;
        end
        vectors++;
        if (first_stuck != last_rise + COND_DELAY + 3 + LIMIT || sl_high == 0 || sl_low == 0) begin
            miscompares++;
            $display("[TB] FAIL stuck_timing got first=%0d hiphase=%0d lophase=%0d expected first=%0d",
                     first_stuck, sl_high, sl_low, last_rise + COND_DELAY + 3 + LIMIT);
        end
    endtask

    task automatic test_saturation();
        int nvalid = 0;
        int nstuck = 0;
        n = 0;
        add_run(0, 4);
        for (int i = 0; i < 2; i++) begin
            add_run(1, 3);
            add_run(0, 252);
        end
        add_run(1, 3);
        add_run(0, 11);
        build_model();
        do_reset(1'b0);
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL saturation k=%0d got %h expected %h", k, observed(), expected(k));
            end
            if (valid) nvalid++;
            if (stuck) nstuck++;
        end
        vectors++;
        if (nvalid != 2 || nstuck != 0 || period !== 8'd255 || high_time !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL saturation_summary got valids=%0d stuck=%0d per=%0d hi=%0d expected 2/0/255/3",
                     nvalid, nstuck, period, high_time);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        int first_hi = -1;
        int first_per = -1;
        n = 0;
        add_run(0, 4);
        for (int i = 0; i < 2; i++) begin
            add_run(1, 3);
            add_run(0, 5);
        end
        add_run(1, 2);
        build_model();
        do_reset(1'b0);
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_pre k=%0d got %h expected %h", k, observed(), expected(k));
            end
        end
        n = 0;
        add_run(1, 1);
        add_run(0, 5);
        for (int i = 0; i < 3; i++) begin
            add_run(1, 3);
            add_run(0, 5);
        end
        add_run(0, 6);
        build_model();
        do_reset(1'b1);
        vectors++;
        if (observed() !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_values got %h expected 0", observed());
        end
        for (int k = 0; k < n; k++) begin
            step(stim[k]);
            vectors++;
            if (observed() !== expected(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_post k=%0d got %h expected %h", k, observed(), expected(k));
            end
            if (valid && nvalid == 0) begin
                first_hi = int'(high_time);
                first_per = int'(period);
            end
            if (valid) nvalid++;
        end
        vectors++;
        if (first_hi != 3 || first_per != 8) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_first got hi=%0d per=%0d expected 3/8", first_hi, first_per);
        end
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 3; iter++) begin
            bit v = 1'b1;
            n = 0;
            add_run(0, $urandom_range(3, 10));
            while (n < 500) begin
                int len = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 270) : $urandom_range(1, 12);
                add_run(v, len);
                v = ~v;
            end
            add_run(0, 6);
            build_model();
            do_reset(stim[0]);
            for (int k = 0; k < n; k++) begin
                step(stim[k]);
                vectors++;
                if (observed() !== expected(k)) begin
                    miscompares++;
                    $display("[TB] FAIL random iter=%0d k=%0d got %h expected %h",
                             iter, k, observed(), expected(k));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_steady();
        test_high_at_reset();
        test_glitch();
        test_stuck();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle of an external PWM-style signal, such as an LED-drive or breathing-PWM line fed back or arriving from another device. It synchronises the asynchronous input, counts high time and full period in clock cycles, and reports each completed period with a one-cycle strobe. A line that stops toggling is flagged as stuck. The block is the receive-side counterpart of the breathing/PWM generators that drive the RGB LED driver, and sits between an input pin and register/debug logic.

## Interface
- `CNT_W`, default 16: width of the high-time and period counters and outputs.
- `clk`, input, 1: system clock (12 MHz oscillator domain).
- `rst`, input, 1: reset, synchronous, active-high.
- `pwm_in`, input, 1: asynchronous PWM input.
- `high_time`, output, CNT_W: clk cycles the conditioned input was high in the last completed period.
- `period`, output, CNT_W: clk cycles from one rising edge to the next (high + low).
- `valid`, output, 1: one-cycle strobe; `high_time` and `period` were updated this cycle.
- `stuck`, output, 1: no edge for 2^CNT_W−1 cycles.
- `stuck_level`, output, 1: conditioned level while `stuck`=1.

## Operation
- Input conditioning: 2-FF synchroniser, optional glitch filter, then edge detect (rise/fall) against the previous conditioned sample. All conditioning flops reset to 0.
- Single counter `cnt` and a registered `hi` latch.
- FSM states and transitions:
  - WAIT_LOW (reset state): go to WAIT_RISE when the conditioned level is 0. This guarantees that an input already high at reset never yields a partial measurement.
  - WAIT_RISE: on a rising edge, set cnt=1 and go to HIGH.
  - HIGH: cnt+1 each cycle. On a falling edge, set hi=cnt, cnt+1, and go to LOW.
  - LOW: cnt+1 each cycle. On a rising edge, set high_time=hi, period=cnt, pulse valid, set cnt=1, and stay in the HIGH path (go to HIGH).
  - STUCK: entered from any state when cnt would exceed 2^CNT_W−1 with no edge that cycle. In STUCK, stuck=1 and stuck_level=the conditioned level. A rising edge clears stuck, sets cnt=1 and goes to HIGH. A falling edge clears stuck and goes to WAIT_RISE.
- In WAIT_LOW and WAIT_RISE, cnt also counts cycles since the last edge so that the timeout applies there too.
- Simultaneous edge and counter saturation: the edge wins and no stuck is raised.
- Counters saturate and never wrap.
- `high_time` and `period` hold their last value until the next valid.
- Minimum measurable values: high_time=1, period=2.
- Reset mid-measurement: the partial measurement is discarded, the FSM returns to WAIT_LOW, and all outputs return to their reset values.

## Timing
- Reset values: high_time=0, period=0, valid=0, stuck=0, stuck_level=0.
- Latency from the clk edge that first samples a `pwm_in` transition to the FSM acting on it: 3 cycles without the filter, 5 cycles with it. `valid` is registered and asserts in that same cycle.
- Throughput: one measurement per input period.
- Measurement accuracy is exact in clk cycles for inputs stable longer than the filter window.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined: the conditioned level changes only after the synchronised input has held a new value for 3 consecutive cycles. Shorter glitches are ignored, and latency is +2.
- Not defined: the synchronised input drives edge detection directly. A 1-cycle pulse is measured as high_time=1.

## Structure
- Package `pwm_capture_pkg`: FSM state encoding (WAIT_LOW, WAIT_RISE, HIGH, LOW, STUCK) and the filter length constant (3).
- Sub-module `pwm_input_cond`: synchroniser, optional filter and edge detect. Outputs are level, rise and fall.
- The FSM and counters live in `pwm_capture`.

## Test plan
All scenarios use CNT_W=8.
- 3 high / 5 low repeating, after the first full period: valid every 8 cycles, high_time=3, period=8.
- `pwm_in`=1 while `rst` is deasserted, then 4 low / 4 high: no valid until a low and a full period are seen; then high_time=4, period=8.
- `pwm_in` held high for 300 cycles: stuck=1 and stuck_level=1 at cycle 255 after the last edge, with no valid. A later rising edge clears stuck on edge detect, and a normal measurement follows.
- One 1-cycle high glitch inside 10-cycle low stretches:
  - With `PWM_CAPTURE_FILTER_EN`: no valid and no change to outputs.
  - Without it: high_time=1, period=11.
- `rst` asserted for 1 cycle in the middle of a HIGH phase: outputs go to 0 and valid=0. The first valid after release comes from a complete fresh period.
- Edge arriving in the same cycle as counter saturation (period=255 exactly): no stuck, valid with period=255.
